// File: rtl/conv_mac_pipe_pkg.sv
// Shared widths and arithmetic helpers for the NPU conv datapath:
// accumulator sizing, window packing and the round/shift/ReLU/saturate requantiser.
package conv_mac_pipe_pkg;

  localparam int K_H_DEF     = 3;
  localparam int K_W_DEF     = 3;
  localparam int IN_W_DEF    = 9;
  localparam int WT_W_DEF    = 8;
  localparam int BIAS_W_DEF  = 16;
  localparam int ACC_W_DEF   = 32;
  localparam int C_MAX_DEF   = 64;
  localparam int OUT_W_DEF   = 8;
  localparam int SHIFT_W_DEF = 5;

  // Smallest accumulator that cannot overflow over a full C_MAX-channel pixel.
  function automatic int acc_w_min(input int in_w, input int wt_w, input int n, input int c_max);
    return in_w + wt_w + $clog2(n * c_max) + 1;
  endfunction

  // LSB of element (r,c) in a row-major packed window.
  function automatic int win_lsb(input int r, input int c, input int k_w, input int w);
    return (r * k_w + c) * w;
  endfunction

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input logic [7:0] s);
    if (s == 8'd0) return v;
    return (v + (64'sd1 <<< (s - 8'd1))) >>> s;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input logic relu,
                                                  input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = relu ? (64'sd1 <<< out_w) - 64'sd1 : (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input logic [7:0] s, input logic relu,
                                                 input int out_w);
    return saturate(round_shift(acc, s), relu, out_w);
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Beat-in / pixel-out valid-ready bundle of the conv MAC pipe.
interface conv_mac_pipe_if
  import conv_mac_pipe_pkg::*;
#(
  parameter int K_H     = K_H_DEF,
  parameter int K_W     = K_W_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int WT_W    = WT_W_DEF,
  parameter int BIAS_W  = BIAS_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
);
  logic                          in_valid;
  logic                          in_ready;
  logic [K_H*K_W*IN_W-1:0]       in_win;
  logic [K_H*K_W*WT_W-1:0]       in_wt;
  logic                          in_first;
  logic                          in_last;
  logic signed [BIAS_W-1:0]      cfg_bias;
  logic [SHIFT_W-1:0]            cfg_shift;
  logic                          cfg_relu;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_W-1:0]              out_data;

  modport master (
    output in_valid, in_win, in_wt, in_first, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_win, in_wt, in_first, in_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_mac_pipe_requant.sv
// Combinational requantiser: ACC_W accumulator to OUT_W pixel via the shared package function.
module conv_mac_pipe_requant
  import conv_mac_pipe_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    relu,
  output logic [OUT_W-1:0]        out
);
  always_comb begin
    out = OUT_W'(requant(64'(acc), 8'(shift), relu, OUT_W));
  end
endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined KxK convolution MAC: products, channel accumulation with bias, requantised pixel out.
// A single global enable stalls every stage when the output is held.
module conv_mac_pipe
  import conv_mac_pipe_pkg::*;
#(
  parameter int K_H     = K_H_DEF,
  parameter int K_W     = K_W_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int WT_W    = WT_W_DEF,
  parameter int BIAS_W  = BIAS_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int C_MAX   = C_MAX_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  conv_mac_pipe_if.slave bus
);
  localparam int N       = K_H * K_W;
  localparam int PROD_W  = IN_W + WT_W;
  localparam int ACC_MIN = acc_w_min(IN_W, WT_W, N, C_MAX);

  generate
    if (ACC_W < ACC_MIN) begin : g_acc_w_check
      $error("conv_mac_pipe: ACC_W too narrow for C_MAX channels");
    end
  endgenerate

  logic en;
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  logic signed [PROD_W-1:0]  prod_c [N];
  logic signed [PROD_W-1:0]  prod_p0 [N];
  logic                      vld_p0, first_p0, last_p0;
  logic signed [BIAS_W-1:0]  bias_p0;
  logic [SHIFT_W-1:0]        shift_p0;
  logic                      relu_p0;

  logic signed [ACC_W-1:0]   sum_c;
  logic signed [ACC_W-1:0]   acc_p1;
  logic                      vld_p1;
  logic [SHIFT_W-1:0]        shift_p1;
  logic                      relu_p1;

  logic [OUT_W-1:0]          rq_c;
  logic                      vld_p2;
  logic [OUT_W-1:0]          data_p2;

  always_comb begin
    logic signed [IN_W-1:0] w;
    logic signed [WT_W-1:0] k;
    for (int e = 0; e < N; e++) begin
      w         = bus.in_win[win_lsb(e / K_W, e % K_W, K_W, IN_W) +: IN_W];
      k         = bus.in_wt[win_lsb(e / K_W, e % K_W, K_W, WT_W) +: WT_W];
      prod_c[e] = PROD_W'(w) * PROD_W'(k);
    end
  end

  // Stage p0: registered products plus per-beat framing and cfg
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else if (en) begin
      vld_p0   <= bus.in_valid;
      first_p0 <= bus.in_first;
      last_p0  <= bus.in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      prod_p0  <= prod_c;
      bias_p0  <= bus.cfg_bias;
      shift_p0 <= bus.cfg_shift;
      relu_p0  <= bus.cfg_relu;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int e = 0; e < N; e++) sum_c = sum_c + ACC_W'(prod_p0[e]);
  end

  // Stage p1: channel accumulation; a first beat restarts from bias and latches the pixel cfg
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      acc_p1   <= '0;
      shift_p1 <= '0;
      relu_p1  <= 1'b0;
    end else if (en) begin
      vld_p1 <= vld_p0 && last_p0;
      if (vld_p0) begin
        acc_p1 <= (first_p0 ? ACC_W'(bias_p0) : acc_p1) + sum_c;
        if (first_p0) begin
          shift_p1 <= shift_p0;
          relu_p1  <= relu_p0;
        end
      end
    end
  end

  conv_mac_pipe_requant #(
    .ACC_W  (ACC_W),
    .SHIFT_W(SHIFT_W),
    .OUT_W  (OUT_W)
  ) u_requant (
    .acc  (acc_p1),
    .shift(shift_p1),
    .relu (relu_p1),
    .out  (rq_c)
  );

  // Stage p2: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= rq_c;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: driver pushes expected pixels, a monitor pops on each handshake.
module tb_conv_mac_pipe;
  localparam int N    = 9;
  localparam int IN_W = 9;
  localparam int WT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_pipe_if bus ();

  conv_mac_pipe dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] held;
  logic [7:0] exp4[8] = '{8'd9, 8'd19, 8'd29, 8'd39, 8'd49, 8'd59, 8'd69, 8'd79};

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare on every accepted output, and check the output is held while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", int'(bus.out_valid), 1);
          chk("hold_data", int'(bus.out_data), int'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0d expected no output", bus.out_data);
          end else begin
            chk("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
          end
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        held      = bus.out_data;
      end
    end
  end

  task automatic send(input int w, input int k, input logic first, input logic last,
                      input int bias, input int sh, input logic relu);
    logic rdy;
    int   n;
    for (int e = 0; e < N; e++) begin
      bus.in_win[e*IN_W +: IN_W] = IN_W'(w);
      bus.in_wt[e*WT_W +: WT_W]  = WT_W'(k);
    end
    bus.in_first  = first;
    bus.in_last   = last;
    bus.cfg_bias  = 16'(bias);
    bus.cfg_shift = 5'(sh);
    bus.cfg_relu  = relu;
    bus.in_valid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) break;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_win    = '0;
    bus.in_wt     = '0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.cfg_bias  = '0;
    bus.cfg_shift = '0;
    bus.cfg_relu  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single-channel pixel and its latency
    exp_q.push_back(8'd9);
    send(1, 1, 1'b1, 1'b1, 0, 0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    chk("latency", n, 3);
    drain();

    // three channels, relu on; non-first beats carry junk cfg
    exp_q.push_back(8'd132);
    send(100, 50, 1'b1, 1'b0, 0, 10, 1'b1);
    send(100, 50, 1'b0, 1'b0, 999, 0, 1'b0);
    send(100, 50, 1'b0, 1'b1, -7, 3, 1'b0);
    // same pixel, signed saturation, with bubbles between beats
    exp_q.push_back(8'd127);
    send(100, 50, 1'b1, 1'b0, 0, 10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(100, 50, 1'b0, 1'b0, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send(100, 50, 1'b0, 1'b1, 0, 0, 1'b1);
    drain();

    // negative accumulator: relu clamps to 0, signed saturates to -128
    exp_q.push_back(8'd0);
    send(-10, 7, 1'b1, 1'b1, 0, 0, 1'b1);
    exp_q.push_back(8'h80);
    send(-10, 7, 1'b1, 1'b1, 0, 2, 1'b0);
    drain();

    // stream of 8 pixels with a 5-cycle downstream stall midway
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(exp4[i]);
          send(1, i + 1, 1'b1, 1'b1, i, 0, 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (bus.out_valid) chk("stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a pixel drops it
    send(1, 1, 1'b1, 1'b0, 100, 0, 1'b0);
    send(1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(8'd23);
    send(1, 2, 1'b1, 1'b1, 5, 0, 1'b0);
    drain();

    // new first while a pixel is open restarts accumulation
    exp_q.push_back(8'd18);
    send(1, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    send(2, 1, 1'b1, 1'b1, 0, 0, 1'b0);
    drain();

    repeat (10) @(posedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
